// File: rtl/otp_ctrl_prog_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : otp_ctrl_prog_seq_if
// Description : OTP macro arbiter port used by the programming sequencer.
//               master = sequencer side, slave = arbiter / macro side.
// Revision    : 1.0 - initial release
// ============================================================================
interface otp_ctrl_prog_seq_if #(
    parameter int ADDR_WIDTH = 11,
    parameter int WORD_WIDTH = 16
) ();

    logic                  otp_req_o;
    logic [1:0]            otp_cmd_o;
    logic [ADDR_WIDTH-1:0] otp_addr_o;
    logic [WORD_WIDTH-1:0] otp_wdata_o;
    logic                  otp_gnt_i;
    logic                  otp_rvalid_i;
    logic [WORD_WIDTH-1:0] otp_rdata_i;
    logic [2:0]            otp_err_i;

    modport master (
        output otp_req_o, otp_cmd_o, otp_addr_o, otp_wdata_o,
        input  otp_gnt_i, otp_rvalid_i, otp_rdata_i, otp_err_i
    );

    modport slave (
        input  otp_req_o, otp_cmd_o, otp_addr_o, otp_wdata_o,
        output otp_gnt_i, otp_rvalid_i, otp_rdata_i, otp_err_i
    );

endinterface
`default_nettype wire

// File: rtl/otp_ctrl_prog_seq.sv
`default_nettype none
// ============================================================================
// Module      : otp_ctrl_prog_seq
// Description : Burns a NUM_WORDS x WORD_WIDTH image into OTP one native word
//               per transaction. Latches the image on request, skips all-zero
//               words, retries transient macro errors and aggregates the first
//               error code. Optional read-back verification is enabled with
//               the macro OTP_CTRL_PROG_VERIFY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module otp_ctrl_prog_seq #(
    parameter int                    NUM_WORDS   = 20,
    parameter int                    WORD_WIDTH  = 16,
    parameter int                    ADDR_WIDTH  = 11,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
    parameter int                    MAX_RETRIES = 2
) (
    input  wire                             clk_i,
    input  wire                             rst_i,
    input  wire                             en_i,
    input  wire  [3:0]                      escalate_en_i,
    input  wire                             req_i,
    input  wire  [NUM_WORDS*WORD_WIDTH-1:0] data_i,
    output logic                            ack_o,
    output logic                            err_o,
    output logic [2:0]                      error_o,
    output logic                            fsm_err_o,
    output logic                            idle_o,
    output logic [$clog2(NUM_WORDS+1)-1:0]  progress_o,
    otp_ctrl_prog_seq_if.master             otp_bus
);

    localparam int                 c_cnt_w       = $clog2(NUM_WORDS);
    localparam int                 c_prog_w      = $clog2(NUM_WORDS+1);
    localparam logic [c_cnt_w-1:0] c_last_cnt    = c_cnt_w'(NUM_WORDS-1);
    localparam logic [2:0]         c_max_retries = 3'(MAX_RETRIES);

    localparam logic [1:0] c_cmd_read  = 2'd0;
    localparam logic [1:0] c_cmd_write = 2'd1;

    localparam logic [2:0] c_err_none  = 3'd0;
    localparam logic [2:0] c_err_macro = 3'd1;
    localparam logic [2:0] c_err_fsm   = 3'd7;
    localparam logic [3:0] c_lc_off    = 4'b1010;

    // Each state is a 3-bit index with every bit replicated five times, so
    // any two valid encodings differ in at least five positions.
    localparam logic [14:0] c_st_reset      = 15'b00000_00000_11111;
    localparam logic [14:0] c_st_idle       = 15'b00000_11111_00000;
    localparam logic [14:0] c_st_write      = 15'b00000_11111_11111;
    localparam logic [14:0] c_st_write_wait = 15'b11111_00000_00000;
    localparam logic [14:0] c_st_error      = 15'b11111_00000_11111;
`ifdef OTP_CTRL_PROG_VERIFY_EN
    localparam logic [14:0] c_st_verify      = 15'b11111_11111_00000;
    localparam logic [14:0] c_st_verify_wait = 15'b11111_11111_11111;
    localparam logic [2:0]  c_err_check      = 3'd6;
`endif

    logic [14:0]           r_state;
    logic [2:0]            r_error;
    logic [c_cnt_w-1:0]    r_cnt;
    logic [c_cnt_w-1:0]    r_cnt_inv;
    logic [2:0]            r_retry;
    logic [c_prog_w-1:0]   r_progress;
    logic [WORD_WIDTH-1:0] r_img [NUM_WORDS];

    logic [14:0]           w_state_d;
    logic [2:0]            w_error_d;
    logic [WORD_WIDTH-1:0] w_word;
    logic [c_cnt_w-1:0]    w_cnt_inc;
    logic                  w_cnt_err;
    logic                  w_escalate;
    logic                  w_last;
    logic                  w_accept;
    logic                  w_advance;
    logic                  w_retry_inc;
    logic                  w_otp_req;
    logic [1:0]            w_otp_cmd;

    assign w_word     = r_img[r_cnt];
    assign w_cnt_inc  = r_cnt + 1'b1;
    // The inverted shadow copy must always be the exact complement.
    assign w_cnt_err  = (r_cnt != ~r_cnt_inv);
    assign w_escalate = (escalate_en_i != c_lc_off);
    assign w_last     = (r_cnt == c_last_cnt);

    // Next-state, error aggregation and handshake decode.
    always_comb begin
        w_state_d   = r_state;
        w_error_d   = r_error;
        w_accept    = 1'b0;
        w_advance   = 1'b0;
        w_retry_inc = 1'b0;
        w_otp_req   = 1'b0;
        w_otp_cmd   = c_cmd_read;
        ack_o       = 1'b0;
        err_o       = 1'b0;
        fsm_err_o   = 1'b0;
        case (r_state)
            c_st_reset: begin
                if (en_i) w_state_d = c_st_idle;
            end
            c_st_idle: begin
                if (req_i) begin
                    w_accept  = 1'b1;
                    w_state_d = c_st_write;
                end
            end
            c_st_write: begin
                // Blank words need no burn; they cost exactly one cycle.
                if (w_word == '0) begin
                    w_advance = 1'b1;
                end else begin
                    w_otp_req = 1'b1;
                    w_otp_cmd = c_cmd_write;
                    if (otp_bus.otp_gnt_i) w_state_d = c_st_write_wait;
                end
            end
            c_st_write_wait: begin
                if (otp_bus.otp_rvalid_i) begin
                    if (otp_bus.otp_err_i == c_err_macro && r_retry < c_max_retries) begin
                        w_retry_inc = 1'b1;
                        w_state_d   = c_st_write;
                    end else if (otp_bus.otp_err_i != c_err_none) begin
                        if (r_error == c_err_none) w_error_d = otp_bus.otp_err_i;
                        w_advance = 1'b1;
                    end else begin
`ifdef OTP_CTRL_PROG_VERIFY_EN
                        w_state_d = c_st_verify;
`else
                        w_advance = 1'b1;
`endif
                    end
                end
            end
`ifdef OTP_CTRL_PROG_VERIFY_EN
            c_st_verify: begin
                w_otp_req = 1'b1;
                w_otp_cmd = c_cmd_read;
                if (otp_bus.otp_gnt_i) w_state_d = c_st_verify_wait;
            end
            c_st_verify_wait: begin
                if (otp_bus.otp_rvalid_i) begin
                    if (otp_bus.otp_err_i != c_err_none) begin
                        if (r_error == c_err_none) w_error_d = otp_bus.otp_err_i;
                    end else if (otp_bus.otp_rdata_i != w_word) begin
                        if (r_error == c_err_none) w_error_d = c_err_check;
                    end
                    w_advance = 1'b1;
                end
            end
`endif
            c_st_error: begin
                if (r_error == c_err_none) w_error_d = c_err_fsm;
            end
            default: begin
                w_state_d = c_st_error;
                fsm_err_o = 1'b1;
                if (r_error == c_err_none) w_error_d = c_err_fsm;
            end
        endcase

        // Finishing a word: complete the run on the last one, else move on.
        if (w_advance) begin
            if (w_last) begin
                ack_o     = 1'b1;
                err_o     = (w_error_d != c_err_none);
                w_state_d = (w_error_d != c_err_none) ? c_st_error : c_st_idle;
            end else begin
                w_state_d = c_st_write;
            end
        end

        // Escalation and counter corruption pre-empt everything else.
        if (w_escalate || w_cnt_err) begin
            w_state_d   = c_st_error;
            fsm_err_o   = 1'b1;
            w_error_d   = (r_error == c_err_none) ? c_err_fsm : r_error;
            w_accept    = 1'b0;
            w_advance   = 1'b0;
            w_retry_inc = 1'b0;
            w_otp_req   = 1'b0;
            w_otp_cmd   = c_cmd_read;
            ack_o       = 1'b0;
            err_o       = 1'b0;
        end
    end

    // State, error code, counters and latched image.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= c_st_reset;
            r_error    <= c_err_none;
            r_cnt      <= '0;
            r_cnt_inv  <= '1;
            r_retry    <= '0;
            r_progress <= '0;
            for (int k = 0; k < NUM_WORDS; k++) r_img[k] <= '0;
        end else begin
            r_state <= w_state_d;
            r_error <= w_error_d;
            if (w_accept) begin
                for (int k = 0; k < NUM_WORDS; k++) begin
                    r_img[k] <= data_i[k*WORD_WIDTH +: WORD_WIDTH];
                end
                r_cnt      <= '0;
                r_cnt_inv  <= '1;
                r_retry    <= '0;
                r_progress <= '0;
            end else if (w_advance) begin
                r_progress <= r_progress + 1'b1;
                if (!w_last) begin
                    r_cnt     <= w_cnt_inc;
                    r_cnt_inv <= ~w_cnt_inc;
                    r_retry   <= '0;
                end
            end else if (w_retry_inc) begin
                r_retry <= r_retry + 1'b1;
            end
        end
    end

    assign error_o    = r_error;
    assign progress_o = r_progress;
    assign idle_o     = (r_state == c_st_idle) || (r_state == c_st_error);

    assign otp_bus.otp_req_o   = w_otp_req;
    assign otp_bus.otp_cmd_o   = w_otp_cmd;
    assign otp_bus.otp_addr_o  = w_otp_req ? (BASE_ADDR + ADDR_WIDTH'(r_cnt)) : '0;
    assign otp_bus.otp_wdata_o = (w_otp_req && w_otp_cmd == c_cmd_write) ? w_word : '0;

endmodule
`default_nettype wire

// File: doc/otp_ctrl_prog_seq.md
Name: otp_ctrl_prog_seq

Overview:
Parametrised successor to the life-cycle programming interface: burns a NumWords x WordWidth image into OTP, one native word per transaction.
Additions over the previous generation:
- Latches the image when the request is accepted.
- Skips all-zero words.
- Retries transient macro errors.
- Optionally reads each word back to verify it.
Sits between a requester (LC controller or DAI-like client) and the OTP macro arbiter. Reports an aggregated error code to the OTP error/alert logic.

Parameters:
NumWords, 20, number of native OTP words per image (>=2)
WordWidth, 16, native OTP word width in bits
AddrWidth, 11, OTP word-address width
BaseAddr, 0, word address of image word 0 (AddrWidth bits)
MaxRetries, 2, extra attempts per word on MacroError (0..7)

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
en_i  in  1  enables the block; leaves ResetSt
escalate_en_i  in  4  lc_tx; any value other than 4'b1010 (Off) means escalate
req_i  in  1  program request (level, sampled in IdleSt)
data_i  in  NumWords*WordWidth  image; word k = bits [k*WordWidth +: WordWidth]
ack_o  out  1  one-cycle completion pulse
err_o  out  1  qualifies ack_o; high = programming failed
error_o  out  3  latched otp_err_e code (0 NoError, 1 MacroError, 4 MacroWriteBlankError, 6 CheckFailError, 7 FsmStateError)
fsm_err_o  out  1  pulses on invalid state, escalation or counter mismatch
idle_o  out  1  high in IdleSt and ErrorSt only
progress_o  out  $clog2(NumWords+1)  number of words completed in current run
otp_req_o  out  1  OTP request
otp_cmd_o  out  2  0 = Read, 1 = Write
otp_addr_o  out  AddrWidth  BaseAddr + cnt
otp_wdata_o  out  WordWidth  word cnt of latched image while otp_req_o and Write, else 0
otp_gnt_i  in  1  OTP grant
otp_rvalid_i  in  1  OTP response valid
otp_rdata_i  in  WordWidth  OTP read data
otp_err_i  in  3  OTP response code

Behaviour:
- Reset (rst_i=1 at clk edge):
  - State ResetSt; all outputs 0 except otp_cmd_o=0.
  - error_o=NoError; cnt, retry and progress cleared.
- States (sparse encoding, Hamming distance >=5): ResetSt, IdleSt, WriteSt, WriteWaitSt, VerifySt, VerifyWaitSt, ErrorSt. Any other encoding -> ErrorSt, fsm_err_o=1.
- ResetSt -> IdleSt when en_i=1.
- IdleSt, req_i=1:
  - Latch data_i into image register; clear cnt and retry.
  - Go to WriteSt next cycle.
  - data_i is don't-care afterwards.
- WriteSt:
  - If image word cnt == 0: no OTP request; advance (see Advance) in the same cycle. A skip costs exactly one cycle.
  - Else: otp_req_o=1, otp_cmd_o=Write; hold until otp_gnt_i, then go to WriteWaitSt.
- WriteWaitSt, on otp_rvalid_i:
  - otp_err_i=MacroError and retry<MaxRetries: retry++, back to WriteSt, same cnt.
  - Any other nonzero code (including MacroError when retries are exhausted): latch into error_q. First error wins, later ones do not overwrite. Advance.
  - NoError: go to VerifySt if the feature is enabled, else Advance.
- Advance:
  - cnt==NumWords-1: ack_o=1 this cycle; err_o=1 if error_d!=NoError.
  - On error, next state is ErrorSt; otherwise IdleSt.
  - Else: cnt++, retry=0, progress++, go to WriteSt.
- ErrorSt: terminal until rst_i. If error_q==NoError, load FsmStateError. Ignores req_i.
- Escalation or counter error overrides everything in that cycle:
  - Next state ErrorSt, fsm_err_o=1.
  - error_q=FsmStateError if it was NoError.
  - No ack_o.
- Redundant counter: cnt is duplicated as an up-counter plus an inverted copy. Mismatch = cnt_err.
- Request arriving while busy is ignored; it is re-sampled only in IdleSt.
- No OTP request is issued outside WriteSt/VerifySt. otp_req_o stays high until grant.

Optional Feature:
Macro OTP_CTRL_PROG_VERIFY_EN.
- Defined:
  - VerifySt issues Read (otp_cmd_o=0) at the same address until grant, then goes to VerifyWaitSt.
  - On otp_rvalid_i: otp_err_i nonzero -> latch that code. Else otp_rdata_i != image word -> latch CheckFailError.
  - Then Advance.
- Undefined: VerifySt/VerifyWaitSt are unreachable (treated as invalid encodings); successful writes advance directly.

Test Plan:
- NumWords=4, image {16'h0001,16'h0000,16'h00F0,16'h1234}, gnt/rvalid one cycle after req, no errors -> 3 writes at BaseAddr+0/2/3, none at +1; ack_o=1 with err_o=0; state IdleSt; progress_o=4.
- Word 2 returns MacroError twice, then NoError (MaxRetries=2) -> 3 writes to addr 2; ack_o=1, err_o=0, error_o=0.
- Word 1 returns MacroWriteBlankError -> remaining words still written; ack_o=1, err_o=1, error_o=4; ErrorSt; later req_i ignored.
- escalate_en_i=4'b0101 mid-run in WriteWaitSt -> next cycle ErrorSt, fsm_err_o pulse, error_o=7, no ack_o; otp_req_o stays 0 afterwards.
- With OTP_CTRL_PROG_VERIFY_EN, readback of word 0 returns 16'h0000 for written 16'h0001 -> error_o=6, ack_o=1 with err_o=1 after the last word.
- rst_i asserted during WriteSt -> next cycle ResetSt, all outputs 0, error_o=0; with en_i=1, IdleSt one cycle later.
